// File: rtl/circle_animator_pkg.sv
// Shared types and ring geometry helpers for the segment-ring animator.
package circle_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   function automatic int unsigned ring_len(input int unsigned n);
      return 2 * n + 4;
   endfunction

   // Flat bit index (7*digit + segment) of ring position p for an n-digit display.
   function automatic int unsigned seg_bit(input int unsigned n, input int unsigned p);
      int unsigned b;
      if (p < n)               b = 7 * p + SEG_A;
      else if (p == n)         b = 7 * (n - 1) + SEG_B;
      else if (p == n + 1)     b = 7 * (n - 1) + SEG_C;
      else if (p <= 2 * n + 1) b = 7 * (2 * n + 1 - p) + SEG_D;
      else if (p == 2 * n + 2) b = SEG_E;
      else                     b = SEG_F;
      return b;
   endfunction

endpackage

// File: rtl/circle_animator_if.sv
// Control and display bundle between the animator and its driver.
interface circle_animator_if
   import circle_pkg::*;
#(
   parameter int unsigned N_DIGITS = 4
) ();
   localparam int unsigned L  = ring_len(N_DIGITS);
   localparam int unsigned PW = $clog2(L);

   logic                  tick_i;
   logic                  run_i;
   logic                  clear_i;
   logic                  dir_i;
   logic [3:0]            speed_i;
   logic [PW-1:0]         pos_o;
   logic [7*N_DIGITS-1:0] seg_o;
   logic                  wrap_o;
   logic                  running_o;

   modport master (
      output tick_i, run_i, clear_i, dir_i, speed_i,
      input  pos_o, seg_o, wrap_o, running_o
   );

   modport slave (
      input  tick_i, run_i, clear_i, dir_i, speed_i,
      output pos_o, seg_o, wrap_o, running_o
   );
endinterface

// File: rtl/circle_animator_seg_decode.sv
// Combinational lit-segment mask for the head and its trail around the ring.
module circle_seg_decode
   import circle_pkg::*;
#(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned TRAIL    = 2
) (
   input  logic [$clog2(ring_len(N_DIGITS))-1:0] pos,
   input  logic                                  dir,
   output logic [7*N_DIGITS-1:0]                 mask
);
   localparam int unsigned L  = ring_len(N_DIGITS);
   localparam int unsigned MW = 7 * N_DIGITS;

   int unsigned base;
   int unsigned p;

   // Trail extends behind the head, i.e. against the direction of travel.
   always_comb begin
      mask = '0;
      base = 32'(pos);
      p    = 0;
      for (int unsigned i = 0; i < TRAIL; i++) begin
         if (dir) p = (base + i) % L;
         else     p = (base + L - i) % L;
         mask = mask | (MW'(1) << seg_bit(N_DIGITS, p));
      end
   end

endmodule

// File: rtl/circle_animator.sv
// Tick-driven ring animator: prescaled stepping FSM with registered segment output.
module circle_animator
   import circle_pkg::*;
#(
   parameter int unsigned N_DIGITS   = 4,
   parameter int unsigned TRAIL      = 2,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input logic              clk_i,
   input logic              rst_ni,
   circle_animator_if.slave bus
);
   localparam int unsigned L  = ring_len(N_DIGITS);
   localparam int unsigned PW = $clog2(L);
   localparam int unsigned MW = 7 * N_DIGITS;
   localparam logic [PW-1:0] LAST  = PW'(L - 1);
   localparam logic [MW-1:0] UNLIT = (ACTIVE_LOW != 0) ? '1 : '0;

   state_t        state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [3:0]    pre_q, pre_d;
   logic          wrap_q, wrap_d;
   logic          tick_q;
   logic          tick_acc;
   logic [MW-1:0] mask;
   logic [MW-1:0] seg_q;

   assign tick_acc = bus.tick_i & ~tick_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         pos_q   <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         pre_q   <= pre_d;
         wrap_q  <= wrap_d;
         tick_q  <= bus.tick_i;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      pre_d   = pre_q;
      wrap_d  = 1'b0;
      if (bus.clear_i) begin
         state_d = S_IDLE;
         pos_d   = '0;
         pre_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.run_i) state_d = S_RUN;
            S_HOLD: if (bus.run_i) state_d = S_RUN;
            S_RUN: begin
               if (!bus.run_i) state_d = S_HOLD;
               if (tick_acc) begin
                  if (pre_q >= bus.speed_i) begin
                     pre_d = '0;
                     if (!bus.dir_i) begin
                        wrap_d = (pos_q == LAST);
                        pos_d  = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                     end else begin
                        wrap_d = (pos_q == '0);
                        pos_d  = (pos_q == '0) ? LAST : pos_q - 1'b1;
                     end
                  end else begin
                     pre_d = pre_q + 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   circle_seg_decode #(
      .N_DIGITS(N_DIGITS),
      .TRAIL   (TRAIL)
   ) u_decode (
      .pos (pos_q),
      .dir (bus.dir_i),
      .mask(mask)
   );

   // Segments refresh only in RUN so HOLD keeps the last picture even if dir_i moves.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         seg_q <= UNLIT;
      else if (bus.clear_i || state_q == S_IDLE)
         seg_q <= UNLIT;
      else if (state_q == S_RUN)
         seg_q <= (ACTIVE_LOW != 0) ? ~mask : mask;
   end

   assign bus.pos_o     = pos_q;
   assign bus.seg_o     = seg_q;
   assign bus.wrap_o    = wrap_q;
   assign bus.running_o = (state_q == S_RUN);

endmodule

// File: tb/tb_circle_animator.sv
// Directed table-driven bench for circle_animator (N_DIGITS=4, TRAIL=2, active-high).
module tb_circle_animator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   circle_animator_if #(.N_DIGITS(4)) bus ();

   circle_animator #(
      .N_DIGITS  (4),
      .TRAIL     (2),
      .ACTIVE_LOW(0)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        run;
      logic        dir;
      logic [3:0]  speed;
      logic        tick;
      logic [3:0]  pos;
      logic        wrap;
      logic [27:0] seg;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic run, input logic dir, input logic [3:0] speed,
                      input logic tick, input logic [3:0] pos, input logic wrap,
                      input logic [27:0] seg);
      vec_t v;
      v.run = run; v.dir = dir; v.speed = speed; v.tick = tick;
      v.pos = pos; v.wrap = wrap; v.seg = seg;
      vecs.push_back(v);
   endtask

   task automatic pulse_tick();
      @(negedge clk) bus.tick_i = 1'b1;
      @(negedge clk) bus.tick_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   logic w;

   initial begin
      bus.tick_i  = 1'b0;
      bus.run_i   = 1'b0;
      bus.clear_i = 1'b0;
      bus.dir_i   = 1'b0;
      bus.speed_i = 4'd0;

      add(1, 0, 0, 0,  0, 0, 28'h0000021);
      add(1, 0, 0, 1,  1, 0, 28'h0000081);
      add(1, 0, 0, 1,  2, 0, 28'h0004080);
      add(1, 0, 0, 1,  3, 0, 28'h0204000);
      add(1, 0, 0, 1,  4, 0, 28'h0600000);
      add(1, 0, 0, 1,  5, 0, 28'h0C00000);
      add(1, 0, 0, 1,  6, 0, 28'h1800000);
      add(1, 0, 0, 1,  7, 0, 28'h1020000);
      add(1, 0, 0, 1,  8, 0, 28'h0020400);
      add(1, 0, 0, 1,  9, 0, 28'h0000408);
      add(1, 0, 0, 1, 10, 0, 28'h0000018);
      add(1, 0, 0, 1, 11, 0, 28'h0000030);
      add(1, 0, 0, 1,  0, 1, 28'h0000021);
      add(1, 1, 0, 1, 11, 1, 28'h0000021);
      add(1, 1, 0, 1, 10, 0, 28'h0000030);
      add(1, 0, 0, 1, 11, 0, 28'h0000030);
      add(1, 0, 0, 1,  0, 1, 28'h0000021);
      add(1, 0, 3, 1,  0, 0, 28'h0000021);
      add(1, 0, 3, 1,  0, 0, 28'h0000021);
      add(1, 0, 3, 1,  0, 0, 28'h0000021);
      add(1, 0, 3, 1,  1, 0, 28'h0000081);
      add(1, 0, 3, 1,  1, 0, 28'h0000081);
      add(1, 0, 3, 1,  1, 0, 28'h0000081);
      add(1, 0, 3, 1,  1, 0, 28'h0000081);
      add(1, 0, 3, 1,  2, 0, 28'h0004080);
      add(1, 0, 3, 1,  2, 0, 28'h0004080);
      add(1, 0, 3, 1,  2, 0, 28'h0004080);
      add(1, 0, 1, 1,  3, 0, 28'h0204000);

      @(negedge clk);
      check("rst_pos", 32'(bus.pos_o), 32'd0);
      check("rst_seg", 32'(bus.seg_o), 32'd0);
      check("rst_wrap", 32'(bus.wrap_o), 32'd0);
      check("rst_running", 32'(bus.running_o), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         bus.run_i   = vecs[i].run;
         bus.dir_i   = vecs[i].dir;
         bus.speed_i = vecs[i].speed;
         bus.tick_i  = vecs[i].tick;
         @(negedge clk);
         bus.tick_i = 1'b0;
         w = bus.wrap_o;
         @(negedge clk);
         check($sformatf("v%0d_pos", i), 32'(bus.pos_o), 32'(vecs[i].pos));
         check($sformatf("v%0d_seg", i), 32'(bus.seg_o), 32'(vecs[i].seg));
         check($sformatf("v%0d_wrap", i), 32'(w), 32'(vecs[i].wrap));
         check($sformatf("v%0d_wrap_end", i), 32'(bus.wrap_o), 32'd0);
         check($sformatf("v%0d_running", i), 32'(bus.running_o), 32'(vecs[i].run));
      end

      // Held-high tick counts once.
      bus.speed_i = 4'd0;
      @(negedge clk) bus.tick_i = 1'b1;
      idle_cycles(10);
      bus.tick_i = 1'b0;
      idle_cycles(2);
      check("held_tick_pos", 32'(bus.pos_o), 32'd4);

      // Hold freezes position, picture and prescale count.
      bus.speed_i = 4'd2;
      pulse_tick();
      check("pre1_pos", 32'(bus.pos_o), 32'd4);
      @(negedge clk) bus.run_i = 1'b0;
      idle_cycles(2);
      check("hold_running", 32'(bus.running_o), 32'd0);
      bus.dir_i = 1'b1;
      for (int k = 0; k < 5; k++) pulse_tick();
      check("hold_pos", 32'(bus.pos_o), 32'd4);
      check("hold_seg", 32'(bus.seg_o), 32'h0600000);
      bus.dir_i = 1'b0;
      bus.run_i = 1'b1;
      idle_cycles(2);
      check("resume_running", 32'(bus.running_o), 32'd1);
      pulse_tick();
      check("resume_pre_pos", 32'(bus.pos_o), 32'd4);
      pulse_tick();
      check("resume_step_pos", 32'(bus.pos_o), 32'd5);

      // Clear wins over a coincident tick and run.
      bus.speed_i = 4'd0;
      @(negedge clk);
      bus.clear_i = 1'b1;
      bus.tick_i  = 1'b1;
      @(negedge clk);
      bus.clear_i = 1'b0;
      bus.tick_i  = 1'b0;
      bus.run_i   = 1'b0;
      check("clr_pos", 32'(bus.pos_o), 32'd0);
      check("clr_seg", 32'(bus.seg_o), 32'd0);
      check("clr_wrap", 32'(bus.wrap_o), 32'd0);
      check("clr_running", 32'(bus.running_o), 32'd0);
      pulse_tick();
      check("idle_tick_pos", 32'(bus.pos_o), 32'd0);
      check("idle_seg", 32'(bus.seg_o), 32'd0);

      // Asynchronous reset mid-run.
      bus.run_i = 1'b1;
      idle_cycles(2);
      pulse_tick();
      pulse_tick();
      check("prerst_pos", 32'(bus.pos_o), 32'd2);
      @(negedge clk) bus.tick_i = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_pos", 32'(bus.pos_o), 32'd0);
      check("arst_seg", 32'(bus.seg_o), 32'd0);
      check("arst_running", 32'(bus.running_o), 32'd0);
      check("arst_wrap", 32'(bus.wrap_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.tick_i = 1'b0;
      idle_cycles(2);
      check("post_rst_running", 32'(bus.running_o), 32'd1);
      check("post_rst_pos", 32'(bus.pos_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
